mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 54 +++++
 rtl/mem_access_unit_load_align.sv | 27 ++
 rtl/mem_access_unit.sv | 110 +++++++++++
 tb/tb_mem_access_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and access-shape helpers for the load/store unit.
// Used by the bus FSM and the load alignment path.
package mem_access_unit_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    // funct3[1:0] encodes the access size for both loads and stores.
    function automatic logic access_ok(input logic is_store, input logic [2:0] funct3,
                                       input logic [1:0] off);
        logic legal;
        logic aligned;
        if (is_store)
            legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        else
            legal = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        case (funct3[1:0])
            2'b01:   aligned = ~off[0];
            2'b10:   aligned = (off == 2'b00);
            default: aligned = 1'b1;
        endcase
        return legal & aligned;
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Selects the addressed byte/half lane of a bus read word and
// sign- or zero-extends it according to the load funct3.
module lsu_load_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = 8'(rdata >> {offset, 3'b000});
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   data = {{24{byte_lane[7]}}, byte_lane};
            F3_LH:   data = {{16{half_lane[15]}}, half_lane};
            F3_LBU:  data = {24'h0, byte_lane};
            F3_LHU:  data = {16'h0, half_lane};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one data-memory bus access per
// legal op, stalls the pipeline until ack or timeout, returns load data.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_m,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [2:0]  funct3M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall_mem,
    output logic [31:0] ReadDataW,
    output logic        load_valid,
    output logic        access_err,
    output logic        timeout_err
);

    localparam logic [9:0] TMO_LAST = 10'(BUS_TIMEOUT - 1);

    state_t      state;
    logic [9:0]  cnt;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic        mem_op;
    logic        op_ok;
    logic        start;
    logic [31:0] load_data;

    assign mem_op    = valid_m & (MemWriteM | (ResultSrcM == RESULT_SRC_LOAD));
    assign op_ok     = access_ok(MemWriteM, funct3M, ALUResultM[1:0]);
    assign start     = (state == IDLE) & mem_op & op_ok;
    assign stall_mem = rst_n & (start | ((state == BUSY) & ~dmem_ack));

    lsu_load_align u_align (
        .rdata  (dmem_rdata),
        .funct3 (funct3_q),
        .offset (off_q),
        .data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            funct3_q    <= '0;
            off_q       <= '0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_be     <= '0;
            dmem_wdata  <= '0;
            ReadDataW   <= '0;
            load_valid  <= 1'b0;
            access_err  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            load_valid  <= 1'b0;
            access_err  <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= BUSY;
                        cnt        <= '0;
                        dmem_req   <= 1'b1;
                        dmem_we    <= MemWriteM;
                        dmem_addr  <= {ALUResultM[31:2], 2'b00};
                        dmem_be    <= lane_be(funct3M[1:0], ALUResultM[1:0]);
                        dmem_wdata <= MemWriteM ? store_data(funct3M[1:0], WriteDataM) : 32'h0;
                        funct3_q   <= funct3M;
                        off_q      <= ALUResultM[1:0];
                    end else if (mem_op) begin
                        access_err <= 1'b1;
                    end
                end
                BUSY: begin
                    // An ack arriving on the last allowed cycle still completes the access.
                    if (dmem_ack) begin
                        state    <= IDLE;
                        dmem_req <= 1'b0;
                        if (!dmem_we) begin
                            ReadDataW  <= load_data;
                            load_valid <= 1'b1;
                        end
                    end else if (cnt == TMO_LAST) begin
                        state       <= IDLE;
                        dmem_req    <= 1'b0;
                        ReadDataW   <= '0;
                        timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset sequences and
// randomized accesses against a byte-lane reference model.
module tb_mem_access_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_m, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM, WriteDataM;
    logic [2:0]  funct3M;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic        stall_mem, load_valid, access_err, timeout_err;
    logic [31:0] ReadDataW;

    int n_total = 0;
    int n_pass  = 0;
    logic [31:0] rdw_model = 32'h0;

    typedef struct {
        bit          go, err, ld, tmo;
        logic [3:0]  be;
        logic [31:0] wdata, rdw;
    } exp_t;

    typedef struct {
        bit          vld, we;
        logic [1:0]  rs;
        logic [2:0]  f3;
        logic [31:0] addr, wd;
        int          d;
        logic [31:0] rd;
        exp_t        e;
    } vec_t;

    vec_t tbl[$];

    mem_access_unit #(.BUS_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .valid_m(valid_m), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .funct3M(funct3M), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .stall_mem(stall_mem), .ReadDataW(ReadDataW),
        .load_valid(load_valid), .access_err(access_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic drive_idle();
        valid_m = 1'b0; MemWriteM = 1'b0; ResultSrcM = 2'b00;
        ALUResultM = 32'h0; WriteDataM = 32'h0; funct3M = 3'd0;
    endtask

    task automatic drive_garbage();
        valid_m = 1'($urandom); MemWriteM = 1'($urandom); ResultSrcM = 2'($urandom);
        ALUResultM = $urandom; WriteDataM = $urandom; funct3M = 3'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: byte-lane arithmetic straight from the access rules.
    function automatic exp_t model(input vec_t v);
        exp_t   e;
        bit     mem, legal;
        int     nb, off;
        longint mask, lane;
        mem   = v.vld && (v.we || v.rs == 2'b01);
        nb    = 1 << v.f3[1:0];
        off   = int'(v.addr[1:0]);
        legal = v.we ? (v.f3 < 3) : (v.f3 < 3 || v.f3 == 4 || v.f3 == 5);
        e.go  = mem && legal && (off % nb == 0);
        e.err = mem && !e.go;
        e.tmo = e.go && v.d > TMO;
        e.ld  = e.go && !v.we && !e.tmo;
        if (nb > 4) nb = 4;
        mask    = (64'd1 << (8 * nb)) - 1;
        e.be    = 4'(((1 << nb) - 1) << (off - off % nb));
        lane    = longint'(v.wd) & mask;
        e.wdata = (nb == 1) ? 32'(lane * 32'h01010101) : (nb == 2) ? 32'(lane * 65537) : v.wd;
        lane    = (longint'(v.rd) >> (8 * off)) & mask;
        if (v.f3 < 4 && nb < 4 && lane > mask / 2) lane = lane - (mask + 1);
        e.rdw   = e.tmo ? 32'h0 : 32'(lane);
        return e;
    endfunction

    function automatic vec_t mkv(input bit vld, we, input logic [1:0] rs, input logic [2:0] f3,
                                 input logic [31:0] addr, wd, input int d, input logic [31:0] rd,
                                 input bit go, err, ld, tmo, input logic [3:0] be,
                                 input logic [31:0] wdata, rdw);
        vec_t v;
        v.vld = vld; v.we = we; v.rs = rs; v.f3 = f3; v.addr = addr; v.wd = wd;
        v.d = d; v.rd = rd;
        v.e.go = go; v.e.err = err; v.e.ld = ld; v.e.tmo = tmo;
        v.e.be = be; v.e.wdata = wdata; v.e.rdw = rdw;
        return v;
    endfunction

    task automatic run_op(input vec_t v, input string tag);
        exp_t e;
        logic [31:0] exp_addr;
        bit acked;
        e = v.e;
        exp_addr = {v.addr[31:2], 2'b00};
        chk({tag, " lv_idle"}, load_valid, 0);
        chk({tag, " ae_idle"}, access_err, 0);
        chk({tag, " te_idle"}, timeout_err, 0);
        chk({tag, " rdw_hold"}, ReadDataW, rdw_model);
        valid_m = v.vld; MemWriteM = v.we; ResultSrcM = v.rs; funct3M = v.f3;
        ALUResultM = v.addr; WriteDataM = v.wd;
        dmem_ack = 1'($urandom); dmem_rdata = $urandom;
        #1;
        chk({tag, " stall_T"}, stall_mem, e.go);
        chk({tag, " req_T"}, dmem_req, 0);
        tick();
        if (!e.go) begin
            drive_idle();
            #1;
            chk({tag, " access_err"}, access_err, e.err);
            chk({tag, " req_none"}, dmem_req, 0);
            chk({tag, " stall_none"}, stall_mem, 0);
            chk({tag, " lv_none"}, load_valid, 0);
        end else begin
            for (int k = 1; k <= TMO; k++) begin
                drive_garbage();
                acked = (k == v.d);
                dmem_ack = acked;
                dmem_rdata = acked ? v.rd : $urandom;
                #1;
                chk({tag, " req_busy"}, dmem_req, 1);
                chk({tag, " addr"}, dmem_addr, exp_addr);
                chk({tag, " we"}, dmem_we, v.we);
                if (v.we) begin
                    chk({tag, " be"}, dmem_be, e.be);
                    chk({tag, " wdata"}, dmem_wdata, e.wdata);
                end
                chk({tag, " stall_busy"}, stall_mem, !acked);
                if (acked) break;
                if (k < TMO) tick();
            end
            tick();
            drive_idle();
            dmem_ack = 1'($urandom);
            #1;
            chk({tag, " req_done"}, dmem_req, 0);
            chk({tag, " stall_done"}, stall_mem, 0);
            chk({tag, " load_valid"}, load_valid, e.ld);
            chk({tag, " timeout_err"}, timeout_err, e.tmo);
            chk({tag, " ae_done"}, access_err, 0);
            if (e.ld || e.tmo) rdw_model = e.rdw;
            chk({tag, " ReadDataW"}, ReadDataW, rdw_model);
        end
        tick();
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0;
        drive_idle();
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        tick(); tick();
        chk("rst dmem_req", dmem_req, 0);
        chk("rst dmem_we", dmem_we, 0);
        chk("rst dmem_addr", dmem_addr, 0);
        chk("rst dmem_be", dmem_be, 0);
        chk("rst dmem_wdata", dmem_wdata, 0);
        chk("rst ReadDataW", ReadDataW, 0);
        chk("rst pulses", {load_valid, access_err, timeout_err}, 0);
        valid_m = 1'b1; MemWriteM = 1'b1; funct3M = 3'd2; ALUResultM = 32'h100;
        #1;
        chk("rst stall_mem", stall_mem, 0);
        drive_idle();
        rst_n = 1'b1;
        tick();

        //             vld we  rs     f3    addr          wd            d  rd             go err ld tmo be       wdata          rdw
        tbl.push_back(mkv(1, 1, 2'b00, 3'd2, 32'h100, 32'hDEADBEEF, 1, 32'h0,        1, 0, 0, 0, 4'b1111, 32'hDEADBEEF, 32'h0));
        tbl.push_back(mkv(1, 0, 2'b01, 3'd0, 32'h203, 32'h0,        4, 32'h80123456, 1, 0, 1, 0, 4'b0000, 32'h0,        32'hFFFFFF80));
        tbl.push_back(mkv(1, 1, 2'b00, 3'd1, 32'h302, 32'h0000ABCD, 2, 32'h0,        1, 0, 0, 0, 4'b1100, 32'hABCDABCD, 32'h0));
        tbl.push_back(mkv(1, 0, 2'b01, 3'd5, 32'h302, 32'h0,        1, 32'hABCD0000, 1, 0, 1, 0, 4'b0000, 32'h0,        32'h0000ABCD));
        tbl.push_back(mkv(1, 0, 2'b01, 3'd2, 32'h101, 32'h0,        1, 32'h0,        0, 1, 0, 0, 4'b0000, 32'h0,        32'h0));
        tbl.push_back(mkv(1, 0, 2'b01, 3'd2, 32'h200, 32'h0,        5, 32'h12345678, 1, 0, 0, 1, 4'b0000, 32'h0,        32'h0));
        tbl.push_back(mkv(1, 0, 2'b01, 3'd1, 32'h206, 32'h0,        2, 32'h80017FFF, 1, 0, 1, 0, 4'b0000, 32'h0,        32'hFFFF8001));
        tbl.push_back(mkv(1, 0, 2'b01, 3'd4, 32'h101, 32'h0,        3, 32'h0000F100, 1, 0, 1, 0, 4'b0000, 32'h0,        32'h000000F1));
        tbl.push_back(mkv(1, 1, 2'b00, 3'd0, 32'h043, 32'h12345677, 1, 32'h0,        1, 0, 0, 0, 4'b1000, 32'h77777777, 32'h0));
        tbl.push_back(mkv(1, 1, 2'b00, 3'd3, 32'h000, 32'h1,        1, 32'h0,        0, 1, 0, 0, 4'b0000, 32'h0,        32'h0));
        tbl.push_back(mkv(1, 0, 2'b01, 3'd6, 32'h000, 32'h0,        1, 32'h0,        0, 1, 0, 0, 4'b0000, 32'h0,        32'h0));
        tbl.push_back(mkv(0, 0, 2'b01, 3'd2, 32'h000, 32'h0,        1, 32'h0,        0, 0, 0, 0, 4'b0000, 32'h0,        32'h0));
        tbl.push_back(mkv(1, 0, 2'b00, 3'd2, 32'h000, 32'h0,        1, 32'h0,        0, 0, 0, 0, 4'b0000, 32'h0,        32'h0));
        tbl.push_back(mkv(1, 1, 2'b01, 3'd2, 32'h010, 32'hCAFEF00D, 1, 32'h0,        1, 0, 0, 0, 4'b1111, 32'hCAFEF00D, 32'h0));
        tbl.push_back(mkv(1, 0, 2'b01, 3'd1, 32'h201, 32'h0,        1, 32'h0,        0, 1, 0, 0, 4'b0000, 32'h0,        32'h0));
        tbl.push_back(mkv(1, 1, 2'b00, 3'd2, 32'h020, 32'h01020304, 4, 32'h0,        1, 0, 0, 0, 4'b1111, 32'h01020304, 32'h0));
        tbl.push_back(mkv(1, 0, 2'b01, 3'd0, 32'h200, 32'h0,        1, 32'h1234567F, 1, 0, 1, 0, 4'b0000, 32'h0,        32'h0000007F));

        foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i));

        // Reset while a load is outstanding: access abandoned, no pulses.
        valid_m = 1'b1; MemWriteM = 1'b0; ResultSrcM = 2'b01; funct3M = 3'd2;
        ALUResultM = 32'h400; dmem_ack = 1'b0;
        #1;
        chk("rstbusy stall_T", stall_mem, 1);
        tick();
        drive_idle();
        #1;
        chk("rstbusy req", dmem_req, 1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rstbusy stall_low", stall_mem, 0);
        tick();
        dmem_ack = 1'b1;
        #1;
        chk("rstbusy req_drop", dmem_req, 0);
        chk("rstbusy pulses", {load_valid, access_err, timeout_err}, 0);
        chk("rstbusy ReadDataW", ReadDataW, 0);
        rst_n = 1'b1;
        tick();
        dmem_ack = 1'b0;
        #1;
        chk("rstbusy idle_req", dmem_req, 0);
        chk("rstbusy idle_lv", load_valid, 0);
        chk("rstbusy idle_stall", stall_mem, 0);
        rdw_model = 32'h0;

        for (int i = 0; i < 150; i++) begin
            v.vld  = ($urandom_range(0, 7) != 0);
            v.we   = 1'($urandom);
            v.rs   = ($urandom_range(0, 3) != 0) ? 2'b01 : 2'($urandom);
            v.f3   = ($urandom_range(0, 4) != 0) ? 3'($urandom_range(0, 2) + ($urandom_range(0, 1) * 4))
                                                 : 3'($urandom);
            v.addr = $urandom;
            if ($urandom_range(0, 2) != 0) v.addr[1:0] = 2'b00;
            v.wd   = $urandom;
            v.d    = $urandom_range(1, TMO + 2);
            v.rd   = $urandom;
            v.e    = model(v);
            run_op(v, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
